// File: rtl/serial_operand_feeder.sv
// Loads a pair of parallel operands plus carry-in and streams them LSB-first to a
// bit-serial adder, framing each operand set with first/last and holding the adder in reset between frames.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             cin,
    output logic             adder_rst,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             carry_q, carry_d;

    logic a_q, a_d;
    logic b_q, b_d;
    logic cin_out_q, cin_out_d;
    logic first_q, first_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic adder_rst_q, adder_rst_d;

    assign in_ready  = (state_q == IDLE);
    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_out_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign adder_rst = adder_rst_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        carry_d     = carry_q;
        a_d         = 1'b0;
        b_d         = 1'b0;
        cin_out_d   = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        busy_d      = 1'b0;
        adder_rst_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_a_d  = op_a;
                    sh_b_d  = op_b;
                    carry_d = op_cin;
                end
            end
            SHIFT: begin
                // An abort leaves every output at its idle default on the next edge.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_d         = sh_a_q[0];
                    b_d         = sh_b_q[0];
                    cin_out_d   = carry_q & (cnt_q == '0);
                    first_d     = (cnt_q == '0);
                    last_d      = (cnt_q == CNT_LAST);
                    busy_d      = 1'b1;
                    adder_rst_d = 1'b0;
                    sh_a_d      = {1'b0, sh_a_q[WIDTH-1:1]};
                    sh_b_d      = {1'b0, sh_b_q[WIDTH-1:1]};
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cin_out_q   <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            adder_rst_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_out_q   <= cin_out_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            adder_rst_q <= adder_rst_d;
        end
    end

    // Operand storage is only read while SHIFT is active, so it needs no reset.
    always_ff @(posedge clk) begin
        sh_a_q  <= sh_a_d;
        sh_b_q  <= sh_b_d;
        carry_q <= carry_d;
    end

endmodule

// File: doc/serial_operand_feeder.md
# serial_operand_feeder

Upstream stage of the bit-serial adder. Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake and shifts them out LSB-first on the `a`, `b` and `cin` lines, one bit per clock. It also drives the adder's active-high reset, so the adder's carry is cleared between frames. Frame markers (`first`, `last`) let the downstream sum collector align the serial `s` stream.

## Interface
- `WIDTH`, 8: operand width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock, shared with the serial adder.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand set present on `op_a`/`op_b`/`op_cin`.
- `in_ready`  out  1  feeder can accept an operand set this cycle.
- `op_a`  in  WIDTH  operand A, parallel.
- `op_b`  in  WIDTH  operand B, parallel.
- `op_cin`  in  1  carry-in for the frame.
- `abort`  in  1  synchronous cancel of the current frame.
- `a`  out  1  serial operand A bit, to adder `a`.
- `b`  out  1  serial operand B bit, to adder `b`.
- `cin`  out  1  to adder `cin`; carries `op_cin` on bit 0 only.
- `adder_rst`  out  1  active-high reset to the serial adder; high whenever no frame is shifting.
- `first`  out  1  current bit is bit 0 of a frame.
- `last`  out  1  current bit is bit WIDTH-1 of a frame.
- `busy`  out  1  frame in progress.

## Operation
- Two states: IDLE and SHIFT.
- Internal state: shift registers `sh_a` and `sh_b` (WIDTH each), a carry latch, and a bit counter `cnt` of width clog2(WIDTH).
- All serial outputs (`a`, `b`, `cin`, `first`, `last`, `busy`, `adder_rst`) are registered.
- `in_ready` is combinational: 1 in IDLE, 0 in SHIFT.
- IDLE:
  - Outputs `a=b=cin=first=last=busy=0`, `adder_rst=1`.
  - On `in_valid & in_ready`: load `op_a`/`op_b`/`op_cin`, set `cnt=0`, go to SHIFT.
- SHIFT, cycle k (k = 0..WIDTH-1):
  - `a=op_a[k]`, `b=op_b[k]`.
  - `cin=op_cin` when k=0, else 0.
  - `first=(k==0)`, `last=(k==WIDTH-1)`, `busy=1`, `adder_rst=0`.
- After the `last` bit: return to IDLE. The following cycle shows `adder_rst=1`, so there is at least one idle cycle between frames and the adder carry is cleared.
- `in_valid` in SHIFT is ignored; the operand inputs are not sampled.
- `abort` in SHIFT: next cycle is IDLE with IDLE output values. The partial frame is discarded and no `last` is issued.
- `abort` in IDLE has no effect. If `abort` and an accept occur in the same cycle, the accept wins.
- Operand inputs are sampled only at accept; later changes to them do not affect the frame in flight.

## Timing
- Reset (`reset=0`, asynchronous) puts the block in IDLE with `a=b=cin=first=last=busy=0`, `adder_rst=1`, `in_ready=1`.
- Reset mid-frame: outputs go to reset values immediately, without waiting for a clock edge. The frame is lost.
- Reset deassertion is synchronized externally. The first accept is possible at the first rising edge after deassertion.
- Latency: accept at edge N → bit 0 on the outputs after edge N+1.
- Bit k is valid between edges N+1+k and N+2+k. The `last` bit is valid after edge N+WIDTH.
- Throughput: one frame per WIDTH+1 cycles with `in_valid` held high.
- The adder samples `a`/`b`/`cin` on the same edges, so the sum bit for bit k appears one cycle after bit k.

## Test plan
- WIDTH=4; after reset, check `in_ready=1`, `adder_rst=1`, and all other outputs 0. Assert `reset` mid-frame → outputs return to reset values before the next clock edge.
- `op_a=4'b1011`, `op_b=4'b0110`, `op_cin=1`, single accept:
  - `a` = 1,1,0,1 and `b` = 0,1,1,0 on consecutive cycles.
  - `cin` = 1,0,0,0.
  - `first` only on bit 0, `last` only on bit 3, `busy` high for exactly 4 cycles.
  - Then `adder_rst=1`, `in_ready=1`.
- Hold `in_valid=1` with frames 4'hF/4'h1/cin=0 then 4'h3/4'h5/cin=1:
  - The two frames are separated by exactly one IDLE cycle with `adder_rst=1`.
  - The second frame's bit-0 `cin` is 1.
  - Changing `op_a` mid-frame does not alter the serial `a`.
- Accept frame 4'hA/4'h5, then pulse `abort` during bit 1 → next cycle IDLE, `last` never asserted. The next accepted frame starts with `first=1` and a correct bit 0.
- Connect the serial adder and a 4-bit collector; run 7+9 cin=0 and 15+15 cin=1 → collected sums 16 and 31 (5-bit result using `cout`).
- Pulse `in_valid` while `busy=1` → ignored: no extra frame and no change to the current bit stream.
